// File: rtl/noc_bench_pkg.sv
// -----------------------------------------------------------------------------
// noc_bench_pkg
// Shared definitions for the mesh traffic injector:
//   - flit field positions (dest / src / reserved / seq)
//   - injector state encoding (IDLE, OFFER, DONE)
//   - default LFSR seed and Galois toggle mask
//   - helpers: one LFSR step, flit packing
// -----------------------------------------------------------------------------
package noc_bench_pkg;

    localparam int FLIT_W   = 32;
    localparam int DEST_LSB = 28;
    localparam int DEST_W   = 4;
    localparam int SRC_LSB  = 24;
    localparam int SRC_W    = 4;
    localparam int RSVD_LSB = 16;
    localparam int RSVD_W   = 8;
    localparam int SEQ_LSB  = 0;
    localparam int SEQ_W    = 16;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_OFFER = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    function automatic logic [FLIT_W-1:0] pack_flit(
        input logic [DEST_W-1:0] dest,
        input logic [SRC_W-1:0]  src,
        input logic [SEQ_W-1:0]  seq
    );
        logic [FLIT_W-1:0] f;
        f                       = '0;
        f[DEST_LSB +: DEST_W]   = dest;
        f[SRC_LSB  +: SRC_W]    = src;
        f[RSVD_LSB +: RSVD_W]   = '0;
        f[SEQ_LSB  +: SEQ_W]    = seq;
        return f;
    endfunction

endpackage

// File: rtl/traffic_injector_if.sv
// -----------------------------------------------------------------------------
// traffic_injector_if
// Valid/ready flit channel from the injector to the router local port.
//   out_valid  flit offered (injector -> router)
//   out_ready  router accepts flit (router -> injector)
//   out_data   32-bit flit (injector -> router)
// Modports: master = injector side, slave = router side.
// -----------------------------------------------------------------------------
interface traffic_injector_if;
    import noc_bench_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [FLIT_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1), one step per clock.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, loads seed
//   seed   value loaded during reset (must be non-zero; tie to a constant)
//   value  current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
    import noc_bench_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] value_q;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of the others; blocking here would create order races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= seed;
        end else begin
            value_q <= lfsr_step(value_q);
        end
    end

    assign value = value_q;

endmodule

// File: rtl/traffic_injector.sv
// -----------------------------------------------------------------------------
// traffic_injector
// Random flit generator for one mesh node. While send is high it rolls an
// LFSR each IDLE cycle; a roll below rate latches a flit and offers it on the
// valid/ready channel until accepted. With send low it parks in DONE.
//
// Parameters: NODE_ID (0..NODES-1), NODES (2..16), SEED (0 -> 16'hACE1)
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset (release synchronized inside)
//   send        injection enable
//   rate[8:0]   injection threshold, 0 = never, 256 = every IDLE cycle
//   out_if      master side of traffic_injector_if (out_valid/out_ready/out_data)
//   sent_count  flits accepted since reset (saturating)
//   stall_count cycles with out_valid & !out_ready (saturating), only when
//               INJ_STALL_STATS_EN is defined
//   done        injector parked in DONE
// Optional feature macro: INJ_STALL_STATS_EN
// -----------------------------------------------------------------------------
module traffic_injector
    import noc_bench_pkg::*;
#(
    parameter int          NODE_ID = 0,
    parameter int          NODES   = 9,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               send,
    input  logic [8:0]         rate,
    traffic_injector_if.master out_if,
    output logic [15:0]        sent_count,
`ifdef INJ_STALL_STATS_EN
    output logic [15:0]        stall_count,
`endif
    output logic               done
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'd0) ? DEFAULT_SEED : SEED;
    localparam logic [4:0]  NODES_L   = 5'(NODES);
    localparam logic [3:0]  NODE_ID_L = 4'(NODE_ID);
    localparam logic [3:0]  NEXT_NODE = 4'((NODE_ID + 1) % NODES);

    // NOTE: reset asserts asynchronously but releases through one flop, so
    // every flop below leaves reset on the same edge and the first real
    // update lands on the second rising edge after release.
    logic rst_sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    logic [15:0] lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (rst_sync_q),
        .seed  (SEED_EFF),
        .value (lfsr)
    );

    // Top nibble of the LFSR is never consumed.
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr[15:12];

    // Destination: fold once into range, then skip our own node.
    logic [3:0] dest_sel;
    logic       hit;

    always_comb begin
        dest_sel = lfsr[11:8];
        if ({1'b0, dest_sel} >= NODES_L) begin
            dest_sel = dest_sel - NODES_L[3:0];
        end
        if (dest_sel == NODE_ID_L) begin
            dest_sel = NEXT_NODE;
        end
    end

    assign hit = ({1'b0, lfsr[7:0]} < rate);

    state_t            state_q, state_d;
    logic [FLIT_W-1:0] flit_q,  flit_d;
    logic [15:0]       seq_q,   seq_d;
    logic [15:0]       sent_q,  sent_d;

    // NOTE: every next-state variable is defaulted to its current value first,
    // so paths that do not assign it cannot infer a latch.
    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
        seq_d   = seq_q;
        sent_d  = sent_q;
        case (state_q)
            ST_IDLE: begin
                if (!send) begin
                    state_d = ST_DONE;
                end else if (hit) begin
                    flit_d  = pack_flit(dest_sel, NODE_ID_L, seq_q);
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Always returns through IDLE, so two handshakes are never adjacent.
                if (out_if.out_ready) begin
                    seq_d   = seq_q + 16'd1;
                    if (sent_q != 16'hFFFF) begin
                        sent_d = sent_q + 16'd1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (send) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_IDLE;
            flit_q  <= '0;
            seq_q   <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            seq_q   <= seq_d;
            sent_q  <= sent_d;
        end
    end

    assign out_if.out_valid = (state_q == ST_OFFER);
    assign out_if.out_data  = flit_q;
    assign sent_count       = sent_q;
    assign done             = (state_q == ST_DONE);

`ifdef INJ_STALL_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            stall_q <= '0;
        end else if (out_if.out_valid && !out_if.out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_traffic_injector.sv
// -----------------------------------------------------------------------------
// tb_traffic_injector
// Directed scenarios plus randomized traffic for traffic_injector, compared
// every falling edge against a transaction-level reference model.
// Build with INJ_STALL_STATS_EN defined to also cover stall_count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_traffic_injector;

    localparam int          NODE_ID = 4;
    localparam int          NODES   = 9;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        send;
    logic [8:0]  rate;
    logic [15:0] sent_count;
    logic        done;
`ifdef INJ_STALL_STATS_EN
    logic [15:0] stall_count;
`endif

    traffic_injector_if u_if ();

    traffic_injector #(
        .NODE_ID (NODE_ID),
        .NODES   (NODES),
        .SEED    (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .send        (send),
        .rate        (rate),
        .out_if      (u_if),
        .sent_count  (sent_count),
`ifdef INJ_STALL_STATS_EN
        .stall_count (stall_count),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Injector behaviour as a pending-flit record: a flit is either being
    // offered or not; the node is either parked or active.
    logic [15:0] m_lfsr  = SEED;
    bit          m_armed = 1'b0;
    bit          m_offer = 1'b0;
    bit          m_park  = 1'b0;
    logic [31:0] m_flit  = '0;
    logic [15:0] m_seq   = '0;
    logic [15:0] m_sent  = '0;
    logic [15:0] m_stall = '0;

    // Polynomial x^16+x^14+x^13+x^11+1: the bit shifted out feeds back into
    // positions 15, 13, 12 and 10 after the right shift.
    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] v);
        int x;
        int out_bit;
        x       = {16'd0, v};
        out_bit = x % 2;
        x       = x / 2;
        if (out_bit == 1) x = x ^ ((1 << 15) | (1 << 13) | (1 << 12) | (1 << 10));
        return 16'(x);
    endfunction

    function automatic logic [3:0] ref_dest(input logic [15:0] l);
        int d;
        d = {28'd0, l[11:8]};
        if (d >= NODES) d = d - NODES;
        if (d == NODE_ID) d = (NODE_ID + 1) % NODES;
        return 4'(d);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lfsr  = SEED;
            m_armed = 1'b0;
            m_offer = 1'b0;
            m_park  = 1'b0;
            m_flit  = '0;
            m_seq   = '0;
            m_sent  = '0;
            m_stall = '0;
        end else if (!m_armed) begin
            m_armed = 1'b1;
        end else begin
            if (m_offer) begin
                if (u_if.out_ready) begin
                    m_offer = 1'b0;
                    m_seq   = m_seq + 16'd1;
                    if (m_sent != 16'hFFFF) m_sent = m_sent + 16'd1;
                end else if (m_stall != 16'hFFFF) begin
                    m_stall = m_stall + 16'd1;
                end
            end else if (m_park) begin
                if (send) m_park = 1'b0;
            end else if (!send) begin
                m_park = 1'b1;
            end else if (rate > {1'b0, m_lfsr[7:0]}) begin
                m_flit  = {ref_dest(m_lfsr), 4'(NODE_ID), 8'h00, m_seq};
                m_offer = 1'b1;
            end
            m_lfsr = ref_lfsr_next(m_lfsr);
        end
    end

    always @(negedge clk) begin
        check("model_valid", 32'(u_if.out_valid), 32'(m_offer));
        check("model_data",  u_if.out_data,       m_flit);
        check("model_sent",  32'(sent_count),     32'(m_sent));
        check("model_done",  32'(done),           32'(m_park));
`ifdef INJ_STALL_STATS_EN
        check("model_stall", 32'(stall_count),    32'(m_stall));
`endif
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!u_if.out_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(u_if.out_valid), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          vcount;
        int          hs;
        logic [3:0]  dest;
        logic [31:0] held;
        bit          ok;

        reset          = 1'b0;
        send           = 1'b0;
        rate           = '0;
        u_if.out_ready = 1'b0;

        // Reset values while reset is held.
        @(negedge clk);
        check("rst_valid", 32'(u_if.out_valid), 32'd0);
        check("rst_data",  u_if.out_data,       32'd0);
        check("rst_sent",  32'(sent_count),     32'd0);
        check("rst_done",  32'(done),           32'd0);

        // Release with send low: DONE must appear only after the second edge.
        reset = 1'b1;
        tick();
        check("sync_edge1_done", 32'(done), 32'd0);
        tick();
        check("sync_edge2_done", 32'(done), 32'd1);

        // rate = 0 never injects.
        send           = 1'b1;
        rate           = 9'd0;
        u_if.out_ready = 1'b1;
        vcount         = 0;
        repeat (1000) begin
            tick();
            if (u_if.out_valid) vcount++;
        end
        check("rate0_valid_cycles", 32'(vcount), 32'd0);
        check("rate0_sent",         32'(sent_count), 32'd0);

        // rate = 256 with a ready router: one flit every two cycles.
        rate = 9'd256;
        hs   = 0;
        for (int i = 0; i < 100; i++) begin
            if (u_if.out_valid && u_if.out_ready) begin
                dest = u_if.out_data[31:28];
                ok   = (dest != 4'(NODE_ID)) && ({28'd0, dest} < NODES);
                check("burst_seq",  32'(u_if.out_data[15:0]),  32'(hs));
                check("burst_src",  32'(u_if.out_data[27:24]), 32'(NODE_ID));
                check("burst_dest", 32'(ok), 32'd1);
                hs++;
            end
            tick();
        end
        check("burst_handshakes", 32'(hs), 32'd50);
        check("burst_sent",       32'(sent_count), 32'd50);

        // Router stalls 20 cycles: flit held stable, then one handshake.
        send           = 1'b1;
        rate           = 9'd256;
        u_if.out_ready = 1'b0;
        do_reset();
        wait_valid("stall_wait", 10);
        held = u_if.out_data;
        for (int i = 0; i < 20; i++) begin
            check("stall_hold_valid", 32'(u_if.out_valid), 32'd1);
            check("stall_hold_data",  u_if.out_data,       held);
            tick();
        end
        u_if.out_ready = 1'b1;
        send           = 1'b0;
        tick();
        check("stall_after_valid", 32'(u_if.out_valid), 32'd0);
        check("stall_after_sent",  32'(sent_count),     32'd1);
`ifdef INJ_STALL_STATS_EN
        check("stall_count", 32'(stall_count), 32'd20);
`endif

        // send drops while offering: flit still completes, then DONE.
        send           = 1'b1;
        rate           = 9'd256;
        u_if.out_ready = 1'b0;
        do_reset();
        wait_valid("late_wait", 10);
        send = 1'b0;
        repeat (5) begin
            tick();
            check("late_hold_valid", 32'(u_if.out_valid), 32'd1);
        end
        u_if.out_ready = 1'b1;
        tick();
        check("late_hs_valid", 32'(u_if.out_valid), 32'd0);
        check("late_hs_sent",  32'(sent_count),     32'd1);
        check("late_hs_done",  32'(done),           32'd0);
        tick();
        check("late_done", 32'(done), 32'd1);

        // Reset pulse mid-offer drops the flit immediately.
        send           = 1'b1;
        rate           = 9'd256;
        u_if.out_ready = 1'b0;
        do_reset();
        wait_valid("rstmid_wait", 10);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_valid", 32'(u_if.out_valid), 32'd0);
        check("rstmid_data",  u_if.out_data,       32'd0);
        check("rstmid_sent",  32'(sent_count),     32'd0);
        @(negedge clk);
        reset          = 1'b1;
        u_if.out_ready = 1'b1;
        wait_valid("rstmid_rewait", 10);
        check("rstmid_first_seq", 32'(u_if.out_data[15:0]), 32'd0);
        tick();
        check("rstmid_first_sent", 32'(sent_count), 32'd1);

        // Counter wrap / saturation.
        send           = 1'b0;
        rate           = 9'd256;
        u_if.out_ready = 1'b1;
        do_reset();
        repeat (3) tick();
        #2;
        force dut.seq_q  = 16'hFFFF;
        force dut.sent_q = 16'hFFFF;
        m_seq  = 16'hFFFF;
        m_sent = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        #2;
        release dut.seq_q;
        release dut.sent_q;
        @(negedge clk);
        send = 1'b1;
        wait_valid("sat_wait1", 10);
        check("sat_seq_before", 32'(u_if.out_data[15:0]), 32'h0000FFFF);
        tick();
        check("sat_sent", 32'(sent_count), 32'h0000FFFF);
        wait_valid("sat_wait2", 10);
        check("sat_seq_wrap", 32'(u_if.out_data[15:0]), 32'd0);

        // Randomized traffic, rate and back-pressure.
        send           = 1'b1;
        u_if.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            send = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 3))
                0:       rate = 9'd0;
                1:       rate = 9'd256;
                2:       rate = 9'($urandom_range(257, 511));
                default: rate = 9'($urandom_range(1, 255));
            endcase
            u_if.out_ready = ($urandom_range(0, 4) < 3);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_injector.md
TRAFFIC_INJECTOR -- requirements
Module: traffic_injector

Interface
REQ-001 Parameter NODE_ID, default 0: this node's address, 0..NODES-1.
REQ-002 Parameter NODES, default 9: number of mesh nodes, 2..16.
REQ-003 Parameter SEED, default 16'hACE1: LFSR seed; value 0 SHALL be replaced by 16'hACE1.
REQ-004 clk  input  1  rising-edge clock; the block's only clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 send  input  1  injection enable, driven by the bench generator.
REQ-007 rate  input  9  injection threshold; 0 = never inject, 256 = every eligible cycle.
REQ-008 out_valid  output  1  flit offered to router local port.
REQ-009 out_ready  input  1  router accepts the flit.
REQ-010 out_data  output  32  flit: [31:28] dest, [27:24] src=NODE_ID, [23:16] 0, [15:0] seq.
REQ-011 sent_count  output  16  flits accepted since reset.
REQ-012 done  output  1  injector idle with send low.

Function
REQ-013 States SHALL be IDLE, OFFER and DONE.
REQ-014 The 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) SHALL advance on every clock edge outside reset.
REQ-015 IDLE, send=1, {1'b0,lfsr[7:0]} < rate: SHALL latch the flit and enter OFFER; out_valid is high from the next cycle.
REQ-016 IDLE, send=1, no hit: SHALL stay in IDLE.
REQ-017 IDLE, send=0: SHALL enter DONE; done=1 from the next cycle.
REQ-018 DONE, send=1: SHALL return to IDLE with done=0 on the next cycle; DONE, send=0: SHALL remain in DONE.
REQ-019 dest SHALL be lfsr[11:8], minus NODES if >= NODES; if the result equals NODE_ID, dest = (NODE_ID+1) mod NODES.
REQ-020 In OFFER, out_data and out_valid SHALL be held stable until out_valid & out_ready.
REQ-021 On handshake: seq += 1 (wraps 16'hFFFF->0), sent_count += 1 (saturates at 16'hFFFF), return to IDLE; out_valid low next cycle.
REQ-022 Minimum spacing is 2 cycles per flit: back-to-back handshakes SHALL be impossible.
REQ-023 send falling during OFFER SHALL NOT retract the flit; the flit completes, then IDLE -> DONE.
REQ-024 rate changes SHALL take effect on the next IDLE evaluation.

Reset
REQ-025 Asserting reset SHALL immediately force: state IDLE, out_valid=0, out_data=0, seq=0, sent_count=0, done=0, lfsr=SEED.
REQ-026 Reset during OFFER SHALL drop the pending flit without counting it.
REQ-027 Reset deassertion SHALL be synchronized internally; the first state update occurs on the second rising edge after release.

Configuration
REQ-028 Macro INJ_STALL_STATS_EN, when defined, SHALL add output stall_count[15:0], reset 0, incremented (saturating) each cycle out_valid=1 & out_ready=0.
REQ-029 Without INJ_STALL_STATS_EN: no stall_count port and no stall logic.

Structure
REQ-030 Package noc_bench_pkg SHALL hold the flit field positions, the state encoding and the default seed constant.
REQ-031 The LFSR SHALL be sub-module lfsr16 (ports clk, reset, seed, value).

Verification
REQ-032 rate=0, send=1, 1000 cycles -> out_valid never high, sent_count=0.
REQ-033 rate=256, out_ready=1, send=1, 100 cycles -> 50 handshakes, seq 0..49, src=NODE_ID, dest != NODE_ID and < NODES on every flit.
REQ-034 rate=256, out_ready=0 for 20 cycles, then 1 -> out_data stable for all 20 cycles, one handshake, sent_count=1; stall_count=20 with INJ_STALL_STATS_EN.
REQ-035 send drops during OFFER, out_ready rises 5 cycles later -> flit accepted, then done=1 on the cycle after IDLE.
REQ-036 Reset pulse during OFFER -> out_valid=0 at once, sent_count=0, first flit after release has seq=0.
REQ-037 Force seq=16'hFFFF and sent_count=16'hFFFF, one handshake -> seq=0, sent_count stays 16'hFFFF.
